// File: rtl/gtx_reset_seq.sv
// Reset sequencer for one GTX refclk group: holds PMA/PLL resets, waits for lock and
// reset-done, then releases per-quad user resets; retries on failure, sticky fail after RETRY_MAX.
module gtx_reset_seq #(
  parameter int N_QUAD         = 3,
  parameter int HOLD_CYCLES    = 256,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int LOCK_STABLE    = 8,
  parameter int USR_RST_CYCLES = 16,
  parameter int RETRY_MAX      = 7
) (
  input  logic                  gtx_refclk_bufr,
  input  logic                  mgt_reset,
  input  logic                  soft_reset,
  input  logic [4*N_QUAD-1:0]   rx_plllkdet,
  input  logic [4*N_QUAD-1:0]   tx_resetdone,
  input  logic [4*N_QUAD-1:0]   rx_resetdone,
  output logic                  pma_reset,
  output logic                  pll_reset,
  output logic [N_QUAD-1:0]     mgt_tx_rst,
  output logic [N_QUAD-1:0]     mgt_rx_rst,
  output logic                  init_done,
  output logic                  lock_fail,
  output logic [3:0]            retry_count,
  output logic [2:0]            seq_state
);

  localparam int L  = 4 * N_QUAD;
  localparam int SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE + 1) : 1;

  localparam logic [19:0]   HOLD_LAST   = 20'(HOLD_CYCLES - 1);
  localparam logic [19:0]   LOCK_LAST   = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0]   USR_LAST    = 20'(USR_RST_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [SW-1:0] STABLE_ONE  = SW'(1);
  localparam logic [3:0]    RETRY_LIM   = 4'(RETRY_MAX);

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    WAIT_DONE  = 3'd2,
    USR_RST    = 3'd3,
    READY      = 3'd4,
    RETRY      = 3'd5,
    FAIL       = 3'd6
  } state_t;

  state_t        state, next;
  logic [L-1:0]  lock_s1, lock_s2, txd_s1, txd_s2, rxd_s1, rxd_s2;
  logic          all_lock, all_done;
  logic [19:0]   timer;
  logic [SW-1:0] stable;

  always_ff @(posedge gtx_refclk_bufr or posedge mgt_reset) begin
    if (mgt_reset) begin
      lock_s1 <= '0; lock_s2 <= '0;
      txd_s1  <= '0; txd_s2  <= '0;
      rxd_s1  <= '0; rxd_s2  <= '0;
    end else begin
      lock_s1 <= rx_plllkdet;  lock_s2 <= lock_s1;
      txd_s1  <= tx_resetdone; txd_s2  <= txd_s1;
      rxd_s1  <= rx_resetdone; rxd_s2  <= rxd_s1;
    end
  end

  assign all_lock  = &lock_s2;
  assign all_done  = (&txd_s2) & (&rxd_s2);
  assign seq_state = state;

  // Success beats timeout in WAIT_LOCK/WAIT_DONE; soft_reset overrides everything.
  always_comb begin
    next = state;
    case (state)
      RESET_HOLD: if (timer == HOLD_LAST) next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (all_lock && stable == STABLE_LAST) next = WAIT_DONE;
        else if (timer == LOCK_LAST)           next = RETRY;
      end
      WAIT_DONE: begin
        if (!all_lock)               next = RETRY;
        else if (all_done)           next = USR_RST;
        else if (timer == LOCK_LAST) next = RETRY;
      end
      USR_RST: begin
        if (!all_lock)              next = RETRY;
        else if (timer == USR_LAST) next = READY;
      end
      READY:   if (!all_lock) next = RETRY;
      RETRY:   next = (retry_count >= RETRY_LIM) ? FAIL : RESET_HOLD;
      FAIL:    next = FAIL;
      default: next = RESET_HOLD;
    endcase
    if (soft_reset) next = RESET_HOLD;
  end

  // Outputs are registered from the next state so they change on the entry edge.
  always_ff @(posedge gtx_refclk_bufr or posedge mgt_reset) begin
    if (mgt_reset) begin
      state       <= RESET_HOLD;
      timer       <= '0;
      stable      <= '0;
      pma_reset   <= 1'b1;
      pll_reset   <= 1'b1;
      mgt_tx_rst  <= '1;
      mgt_rx_rst  <= '1;
      init_done   <= 1'b0;
      lock_fail   <= 1'b0;
      retry_count <= '0;
    end else begin
      state      <= next;
      timer      <= (soft_reset || next != state) ? 20'd0 : timer + 20'd1;
      stable     <= (state == WAIT_LOCK && next == WAIT_LOCK && all_lock) ? stable + STABLE_ONE : '0;
      pma_reset  <= (next == RESET_HOLD) || (next == RETRY) || (next == FAIL);
      pll_reset  <= (next == RESET_HOLD) || (next == RETRY) || (next == FAIL);
      mgt_tx_rst <= {N_QUAD{next != READY}};
      mgt_rx_rst <= {N_QUAD{next != READY}};
      init_done  <= (next == READY);
      if (soft_reset) begin
        retry_count <= '0;
        lock_fail   <= 1'b0;
      end else begin
        if (next == RETRY && state != RETRY && retry_count != 4'hF)
          retry_count <= retry_count + 4'd1;
        lock_fail <= lock_fail | (next == FAIL);
      end
    end
  end

endmodule

// File: tb/tb_gtx_reset_seq.sv
// Scoreboard bench for gtx_reset_seq with shortened hold/timeout so every path fits in a short run.
module tb_gtx_reset_seq;

  localparam int NQ   = 3;
  localparam int L    = 4 * NQ;
  localparam int HOLD = 32;
  localparam int TMO  = 300;
  localparam int STAB = 8;
  localparam int USR  = 16;
  localparam int RMAX = 7;
  localparam int READY_FROM_DROP = 100 + 2 + STAB + 50 + 2 + USR;
  localparam logic [16:0] RST_VEC = {1'b1, 1'b1, 3'b111, 3'b111, 1'b0, 1'b0, 4'd0, 3'd0};

  logic          clk = 1'b0;
  logic          mgt_reset = 1'b1;
  logic          soft_reset = 1'b0;
  logic [L-1:0]  lock = '0, txd = '0, rxd = '0;
  logic          pma_reset, pll_reset, init_done, lock_fail;
  logic [NQ-1:0] mgt_tx_rst, mgt_rx_rst;
  logic [3:0]    retry_count;
  logic [2:0]    seq_state;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];

  gtx_reset_seq #(
    .N_QUAD(NQ), .HOLD_CYCLES(HOLD), .LOCK_TIMEOUT(TMO),
    .LOCK_STABLE(STAB), .USR_RST_CYCLES(USR), .RETRY_MAX(RMAX)
  ) dut (
    .gtx_refclk_bufr(clk), .mgt_reset(mgt_reset), .soft_reset(soft_reset),
    .rx_plllkdet(lock), .tx_resetdone(txd), .rx_resetdone(rxd),
    .pma_reset(pma_reset), .pll_reset(pll_reset),
    .mgt_tx_rst(mgt_tx_rst), .mgt_rx_rst(mgt_rx_rst),
    .init_done(init_done), .lock_fail(lock_fail),
    .retry_count(retry_count), .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] out_vec();
    return {15'd0, pma_reset, pll_reset, mgt_tx_rst, mgt_rx_rst, init_done, lock_fail, retry_count, seq_state};
  endfunction

  task automatic apply_reset();
    mgt_reset = 1'b1; soft_reset = 1'b0;
    lock = '0; txd = '0; rxd = '0;
    repeat (3) @(posedge clk);
    #1 mgt_reset = 1'b0;
  endtask

  // Models the GTX: locks rise 100 cycles after pma_reset falls, done 60 cycles after that.
  task automatic bring_up(input logic [2:0] stop, output int stop_cyc, output int drop_cyc);
    int cyc;
    cyc = 0; stop_cyc = -1; drop_cyc = -1;
    while (cyc < 2000 && stop_cyc < 0) begin
      @(posedge clk); cyc++; #1;
      if (drop_cyc < 0 && pma_reset === 1'b0) drop_cyc = cyc;
      if (drop_cyc >= 0 && cyc == drop_cyc + 100) lock = '1;
      if (drop_cyc >= 0 && cyc == drop_cyc + 160) begin txd = '1; rxd = '1; end
      if (seq_state === stop) stop_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    logic [31:0] e;
    mgt_reset = 1'b1;
    exp_q.push_back({15'd0, RST_VEC});
    repeat (2) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (out_vec() !== e) $display("[TB] FAIL reset_values: got %h expected %h", out_vec(), e);
    else passes++;
  endtask

  task automatic test_bringup();
    int rdy, drop, d;
    logic [31:0] e;
    apply_reset();
    exp_q.push_back(32'(HOLD));
    exp_q.push_back(32'(HOLD + READY_FROM_DROP));
    bring_up(3'd4, rdy, drop);
    e = exp_q.pop_front();
    checks++;
    if (drop !== int'(e)) $display("[TB] FAIL pma_release_cycle: got %0d expected %0d", drop, e);
    else passes++;
    e = exp_q.pop_front();
    d = rdy - int'(e);
    checks++;
    if (rdy < 0 || d > 1 || d < -1) $display("[TB] FAIL init_done_cycle: got %0d expected %0d +-1", rdy, e);
    else passes++;
    checks++;
    if (init_done !== 1'b1 || retry_count !== 4'd0)
      $display("[TB] FAIL ready_status: got init_done=%b retry=%0d expected 1/0", init_done, retry_count);
    else passes++;
    checks++;
    if (mgt_tx_rst !== '0 || mgt_rx_rst !== '0 || pma_reset !== 1'b0)
      $display("[TB] FAIL ready_resets: got tx=%b rx=%b pma=%b expected 000/000/0", mgt_tx_rst, mgt_rx_rst, pma_reset);
    else passes++;
  endtask

  task automatic test_ready_drop();
    int rdy, drop, seen;
    seen = -1;
    lock[0] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      if (i == 1) lock[0] = 1'b1;
      if (seen < 0 && init_done === 1'b0 && mgt_tx_rst === '1 && mgt_rx_rst === '1) seen = i;
    end
    checks++;
    if (seen < 0) $display("[TB] FAIL drop_response: got no reset within 3 cycles, expected init_done=0 resets=1");
    else passes++;
    exp_q.push_back(32'd1);
    bring_up(3'd4, rdy, drop);
    checks++;
    if (rdy < 0 || retry_count !== exp_q.pop_front())
      $display("[TB] FAIL drop_restart: got ready_cyc=%0d retry=%0d expected ready with retry 1", rdy, retry_count);
    else passes++;
  endtask

  task automatic test_lock_timeout_fail();
    int cyc, wd_seen;
    logic [3:0] prev;
    logic [31:0] e;
    apply_reset();
    lock = '1; lock[5] = 1'b0; txd = '1; rxd = '1;
    for (int k = 1; k <= RMAX; k++) begin
      exp_q.push_back(32'(k));
      exp_q.push_back(32'(HOLD + TMO + (k - 1) * (HOLD + TMO + 1)));
    end
    cyc = 0; wd_seen = 0; prev = 4'd0;
    while (cyc < 3000 && seq_state !== 3'd6) begin
      @(posedge clk); cyc++; #1;
      if (seq_state === 3'd2) wd_seen = 1;
      if (retry_count !== prev && exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        checks++;
        if (retry_count !== e[3:0]) $display("[TB] FAIL retry_value: got %0d expected %0d", retry_count, e);
        else passes++;
        e = exp_q.pop_front();
        checks++;
        if (cyc !== int'(e)) $display("[TB] FAIL retry_cycle: got %0d expected %0d", cyc, e);
        else passes++;
        prev = retry_count;
      end
    end
    checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL retry_events: got %0d missing expected 0", exp_q.size() / 2);
    else passes++;
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (seq_state !== 3'd6 || lock_fail !== 1'b1 || pma_reset !== 1'b1 || pll_reset !== 1'b1 || retry_count !== 4'd7)
      $display("[TB] FAIL fail_state: got state=%0d lf=%b pma=%b pll=%b retry=%0d expected 6/1/1/1/7",
               seq_state, lock_fail, pma_reset, pll_reset, retry_count);
    else passes++;
    checks++;
    if (wd_seen != 0) $display("[TB] FAIL no_wait_done_lane5: got WAIT_DONE entered expected never");
    else passes++;
  endtask

  task automatic test_soft_reset();
    int rdy, drop, d;
    soft_reset = 1'b1;
    lock = '0; txd = '0; rxd = '0;
    @(posedge clk); #1;
    soft_reset = 1'b0;
    checks++;
    if (seq_state !== 3'd0 || lock_fail !== 1'b0 || retry_count !== 4'd0)
      $display("[TB] FAIL soft_reset: got state=%0d lf=%b retry=%0d expected 0/0/0", seq_state, lock_fail, retry_count);
    else passes++;
    exp_q.push_back(32'(READY_FROM_DROP));
    bring_up(3'd4, rdy, drop);
    d = rdy - drop - int'(exp_q.pop_front());
    checks++;
    if (rdy < 0 || drop < 0 || d > 1 || d < -1 || init_done !== 1'b1 || retry_count !== 4'd0)
      $display("[TB] FAIL soft_bringup: got ready-drop=%0d init=%b retry=%0d expected %0d+-1/1/0",
               rdy - drop, init_done, retry_count, READY_FROM_DROP);
    else passes++;
  endtask

  task automatic test_lock_toggle();
    int cyc, wd_seen, inc_cyc;
    apply_reset();
    txd = '1; rxd = '1;
    exp_q.push_back(32'(HOLD + TMO));
    cyc = 0; wd_seen = 0; inc_cyc = -1;
    while (cyc < 800 && inc_cyc < 0) begin
      @(posedge clk); cyc++; #1;
      lock = ((cyc / 5) % 2 == 1) ? '1 : '0;
      if (seq_state === 3'd2) wd_seen = 1;
      if (retry_count === 4'd1) inc_cyc = cyc;
    end
    checks++;
    if (inc_cyc !== int'(exp_q.pop_front()))
      $display("[TB] FAIL toggle_timeout_cycle: got %0d expected %0d", inc_cyc, HOLD + TMO);
    else passes++;
    checks++;
    if (wd_seen != 0) $display("[TB] FAIL toggle_no_wait_done: got WAIT_DONE entered expected never");
    else passes++;
  endtask

  task automatic test_mgt_reset_mid();
    int rdy, drop, d;
    apply_reset();
    bring_up(3'd3, rdy, drop);
    checks++;
    if (rdy < 0) $display("[TB] FAIL reach_usr_rst: got timeout expected state 3");
    else passes++;
    #2 mgt_reset = 1'b1;
    exp_q.push_back({15'd0, RST_VEC});
    #1;
    checks++;
    if (out_vec() !== exp_q.pop_front()) $display("[TB] FAIL async_reset: got %h expected %h", out_vec(), RST_VEC);
    else passes++;
    lock = '0; txd = '0; rxd = '0;
    repeat (3) @(posedge clk);
    #1 mgt_reset = 1'b0;
    exp_q.push_back(32'(HOLD + READY_FROM_DROP));
    bring_up(3'd4, rdy, drop);
    d = rdy - int'(exp_q.pop_front());
    checks++;
    if (rdy < 0 || d > 1 || d < -1 || retry_count !== 4'd0)
      $display("[TB] FAIL post_reset_bringup: got ready=%0d retry=%0d expected %0d+-1/0",
               rdy, retry_count, HOLD + READY_FROM_DROP);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_ready_drop();
    test_lock_timeout_fail();
    test_soft_reset();
    test_lock_toggle();
    test_mgt_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
